// File: rtl/mem_xfer_sequencer.sv
// mem_xfer_sequencer
// Initiator-side sequencer for the Chip-8 memory manager. Accepts block
// transfer requests (FX55/FX65, sprite, BCD) and 2-byte opcode fetches, and
// drives the memory manager's step counter, write strobe, base address and
// store buffer. Completion is signalled with a one-cycle pulse; read data is
// latched as a 16-byte block.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_req             opcode fetch request (level, sampled in IDLE)
//   xfer_req              block transfer request (level, sampled in IDLE)
//   xfer_write            1 = store, 0 = load
//   xfer_addr             block base address
//   xfer_len              byte count minus 1
//   xfer_wdata            store data, byte k at [8k+7:8k]
//   mem_read_buffer       read block from memory manager
//   busy                  state != IDLE
//   xfer_done/fetch_done  one-cycle completion pulses
//   xfer_rdata            latched read block
//   mem_address           latched base address
//   mem_address_counter   step counter (0..16)
//   mem_write_enable      write strobe
//   mem_write_count       constant 4'hF
//   mem_write_buffer      latched store data
module mem_xfer_sequencer #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              xfer_req,
  input  logic              xfer_write,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic [3:0]        xfer_len,
  input  logic [127:0]      xfer_wdata,
  input  logic [127:0]      mem_read_buffer,
  output logic              busy,
  output logic              xfer_done,
  output logic              fetch_done,
  output logic [127:0]      xfer_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [CNT_W-1:0]  mem_address_counter,
  output logic              mem_write_enable,
  output logic [3:0]        mem_write_count,
  output logic [127:0]      mem_write_buffer
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [127:0]        wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [127:0]        rdata_q, rdata_d;
  logic                xfer_done_q, xfer_done_d;
  logic                fetch_done_q, fetch_done_d;
  logic [4:0]          last_cnt;

  // Final counter value of a transfer; len 15 reaches 16, hence 5 bits.
  assign last_cnt = {1'b0, len_q} + 5'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    xfer_done_d  = 1'b0;
    fetch_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = ST_FETCH;
        end else if (xfer_req) begin
          state_d = ST_XFER;
          addr_d  = xfer_addr;
          len_d   = xfer_len;
          wdata_d = xfer_wdata;
          write_d = xfer_write;
        end
      end
      ST_FETCH: begin
        if (cnt_q == 5'd1) begin
          state_d      = ST_IDLE;
          fetch_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_XFER: begin
        if (cnt_q == last_cnt) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        xfer_done_d = 1'b1;
        rdata_d     = mem_read_buffer;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      xfer_done_q  <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      xfer_done_q  <= xfer_done_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign busy                = (state_q != ST_IDLE);
  assign xfer_done           = xfer_done_q;
  assign fetch_done          = fetch_done_q;
  assign xfer_rdata          = rdata_q;
  assign mem_address         = addr_q;
  assign mem_address_counter = CNT_W'(cnt_q);
  // Counter 0 is the pipeline priming step of the memory manager; no write.
  assign mem_write_enable    = write_q && (state_q == ST_XFER) && (cnt_q != 5'd0);
  assign mem_write_count     = 4'hF;
  assign mem_write_buffer    = wdata_q;

endmodule
